xor_cipher_cfg_loader: RTL

- Upstream feeder for the XOR cipher's 131-bit serial configuration chain (k_mux, a_mux, d_en, 64-bit taps, 64-bit LFSR state).
- Accepts the configuration as 17 bytes over a valid/ready byte interface, then drives cfg_en/cfg_i for exactly 131 consecutive cycles so the cipher's load pulse fires once.
- Captures the bits the cipher shifts out on cfg_o (its previous configuration) for optional host readback.

---
 rtl/xor_cipher_cfg_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/xor_cipher_cfg_loader.sv
// Byte-wide loader for the XOR cipher's serial configuration chain.
// Optional readback of the displaced configuration: define XOR_CIPHER_CFG_READBACK_EN.
module xor_cipher_cfg_loader #(
  parameter int CFG_BITS  = 131,
  parameter int NUM_BYTES = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clear,
  output logic       busy,
  output logic       done,
  output logic       cfg_en,
  output logic       cfg_i,
  input  logic       cfg_rx,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready
);
  localparam int BCW = $clog2(NUM_BYTES + 1);
  localparam int BIW = $clog2(CFG_BITS);

  // Handshakes: a byte moves on in_valid & in_ready (or rd_valid & rd_ready)
  // at a rising clk edge; the sender holds data stable until it moves.
  typedef enum logic [1:0] {FILL, SHIFT, READOUT} state_t;

  state_t         state, state_nxt;
  logic [BCW-1:0] byte_cnt;
  logic [BIW-1:0] bit_cnt;
  logic [CFG_BITS-1:0] shadow;
  logic           accept, last_byte, last_bit;

  // in_ready stays low during the done cycle so the next frame starts after it.
  assign in_ready  = (state == FILL) && !done;
  assign busy      = (state == SHIFT) || (state == READOUT);
  assign accept    = in_valid && in_ready && !clear;
  assign last_byte = (byte_cnt == BCW'(NUM_BYTES - 1));
  assign last_bit  = (bit_cnt == BIW'(CFG_BITS - 1));

`ifdef XOR_CIPHER_CFG_READBACK_EN
  logic [BCW-1:0]          rd_idx;
  logic [CFG_BITS-1:0]     capture;
  logic [8*NUM_BYTES-1:0]  capture_ext;
  logic                    rd_last;

  assign rd_last     = (rd_idx == BCW'(NUM_BYTES - 1));
  assign capture_ext = {{(8*NUM_BYTES-CFG_BITS){1'b0}}, capture};
  assign rd_data     = rd_valid ? capture_ext[{rd_idx, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture  <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (cfg_en) capture <= {cfg_rx, capture[CFG_BITS-1:1]};
      if (state == READOUT) begin
        if (done) begin
          rd_valid <= 1'b1;
        end else if (rd_valid && rd_ready) begin
          if (rd_last) begin
            rd_valid <= 1'b0;
            rd_idx   <= '0;
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end
      end
    end
  end
`else
  logic unused_rx;
  assign unused_rx = cfg_rx ^ rd_ready;
  assign rd_data   = 8'h00;
  assign rd_valid  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (accept && last_byte) state_nxt = SHIFT;
      SHIFT: begin
`ifdef XOR_CIPHER_CFG_READBACK_EN
        if (last_bit) state_nxt = READOUT;
`else
        if (last_bit) state_nxt = FILL;
`endif
      end
      READOUT: begin
`ifdef XOR_CIPHER_CFG_READBACK_EN
        if (rd_valid && rd_ready && rd_last) state_nxt = FILL;
`else
        state_nxt = FILL;
`endif
      end
      default: state_nxt = FILL;
    endcase
  end

  // cfg_i is preloaded with shadow[0] on the last accept so cfg_en and the
  // first bit appear together on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      bit_cnt  <= '0;
      shadow   <= '0;
      cfg_en   <= 1'b0;
      cfg_i    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FILL: begin
          if (clear) begin
            byte_cnt <= '0;
          end else if (accept) begin
            for (int i = 0; i < CFG_BITS; i++)
              if (byte_cnt == BCW'(i / 8)) shadow[i] <= in_data[i % 8];
            if (last_byte) begin
              byte_cnt <= '0;
              bit_cnt  <= '0;
              cfg_en   <= 1'b1;
              cfg_i    <= shadow[0];
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        SHIFT: begin
          shadow <= {1'b0, shadow[CFG_BITS-1:1]};
          if (last_bit) begin
            cfg_en  <= 1'b0;
            cfg_i   <= 1'b0;
            done    <= 1'b1;
            bit_cnt <= '0;
          end else begin
            cfg_i   <= shadow[1];
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
